// File: rtl/ascon_pkg.sv
// Shared ASCON definitions: rate geometry, padding byte and the AD packer state encoding.
package ascon_pkg;

  localparam int unsigned RATE_BYTES = 8;
  localparam logic [7:0]  PAD_BYTE   = 8'h80;

  typedef logic [2:0] lane_t;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StHold,
    StPadBlk,
    StDone
  } ad_state_e;

  // Lane 0 is the most significant byte of the rate block.
  function automatic logic [8*RATE_BYTES-1:0] lane_put(input logic [8*RATE_BYTES-1:0] d,
                                                        input lane_t lane,
                                                        input logic [7:0] b);
    logic [8*RATE_BYTES-1:0] r;
    r = d;
    r[8*(RATE_BYTES-1-32'(lane)) +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/ad_block_packer.sv
// Packs host AD bytes into 64-bit rate blocks for the AD loader.
// Define AD_PAD_EN to insert the 0x80 padding byte here rather than in the consumer.
module ad_block_packer
  import ascon_pkg::*;
#(
  parameter int unsigned MAX_AD_BYTES = 15
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        start,
  input  logic        ad_empty,
  input  logic [7:0]  ad_byte,
  input  logic        ad_valid,
  input  logic        ad_last,
  output logic        ad_ready,
  input  logic        AD_read,
  output logic        block_valid,
  output logic [63:0] block_data,
  output logic [3:0]  block_len,
  output logic        block_last,
  output logic [3:0]  ad_total,
  output logic        ad_err,
  output logic        done
);

  localparam logic [3:0] MaxTotal = 4'(MAX_AD_BYTES);
  localparam lane_t      LastLane = 3'(RATE_BYTES - 1);

  ad_state_e   state_q, state_d;
  lane_t       cnt_q, cnt_d;
  logic [63:0] data_q, data_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  total_q, total_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic        padp_q, padp_d;
  logic [7:0]  pad_val;

`ifdef AD_PAD_EN
  assign pad_val = PAD_BYTE;
`else
  assign pad_val = 8'h00;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    len_d   = len_q;
    total_d = total_q;
    last_d  = last_q;
    err_d   = err_q;
    padp_d  = padp_q;

    if (start) begin
      cnt_d   = '0;
      data_d  = '0;
      len_d   = '0;
      total_d = '0;
      last_d  = 1'b0;
      err_d   = 1'b0;
      padp_d  = 1'b0;
      state_d = ad_empty ? StDone : StFill;
    end else begin
      unique case (state_q)
        StFill: begin
          if (ad_valid) begin
            if (err_q || (total_q == MaxTotal)) begin
              // Overflow bytes are swallowed; a partial block collected so far is still flushed.
              err_d = 1'b1;
              if (ad_last) begin
                if (cnt_q != '0) begin
                  len_d   = {1'b0, cnt_q};
                  last_d  = 1'b1;
                  data_d  = lane_put(data_q, cnt_q, pad_val);
                  state_d = StHold;
                end else begin
                  state_d = StDone;
                end
              end
            end else begin
              total_d = total_q + 4'd1;
              data_d  = lane_put(data_q, cnt_q, ad_byte);
              cnt_d   = cnt_q + 3'd1;
              if (cnt_q == LastLane) begin
                len_d   = 4'd8;
                last_d  = 1'b0;
                padp_d  = ad_last;
                state_d = StHold;
              end else if (ad_last) begin
                len_d   = {1'b0, cnt_q} + 4'd1;
                last_d  = 1'b1;
                data_d  = lane_put(lane_put(data_q, cnt_q, ad_byte), cnt_q + 3'd1, pad_val);
                state_d = StHold;
              end
            end
          end
        end
        StHold: begin
          if (AD_read) begin
            if (last_q) begin
              state_d = StDone;
            end else if (padp_q) begin
              data_d  = lane_put('0, '0, pad_val);
              len_d   = '0;
              last_d  = 1'b1;
              padp_d  = 1'b0;
              state_d = StPadBlk;
            end else begin
              cnt_d   = '0;
              data_d  = '0;
              state_d = StFill;
            end
          end
        end
        StPadBlk: begin
          if (AD_read) state_d = StDone;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      total_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      padp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      len_q   <= len_d;
      total_q <= total_d;
      last_q  <= last_d;
      err_q   <= err_d;
      padp_q  <= padp_d;
    end
  end

  assign ad_ready    = (state_q == StFill);
  assign block_valid = (state_q == StHold) || (state_q == StPadBlk);
  // Gate block fields so the partially filled register never leaks onto the outputs.
  assign block_data  = block_valid ? data_q : '0;
  assign block_len   = block_valid ? len_q : '0;
  assign block_last  = block_valid ? last_q : 1'b0;
  assign ad_total    = total_q;
  assign ad_err      = err_q;
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_ad_block_packer.sv
// Self-checking bench for ad_block_packer: table of messages plus hand-written corner sequences.
module tb_ad_block_packer;

  localparam int MaxAd = 15;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        start = 1'b0;
  logic        ad_empty = 1'b0;
  logic [7:0]  ad_byte = '0;
  logic        ad_valid = 1'b0;
  logic        ad_last = 1'b0;
  logic        ad_ready;
  logic        AD_read = 1'b0;
  logic        block_valid;
  logic [63:0] block_data;
  logic [3:0]  block_len;
  logic        block_last;
  logic [3:0]  ad_total;
  logic        ad_err;
  logic        done;

  ad_block_packer #(.MAX_AD_BYTES(MaxAd)) dut (
    .clk        (clk),
    .nRST       (nRST),
    .start      (start),
    .ad_empty   (ad_empty),
    .ad_byte    (ad_byte),
    .ad_valid   (ad_valid),
    .ad_last    (ad_last),
    .ad_ready   (ad_ready),
    .AD_read    (AD_read),
    .block_valid(block_valid),
    .block_data (block_data),
    .block_len  (block_len),
    .block_last (block_last),
    .ad_total   (ad_total),
    .ad_err     (ad_err),
    .done       (done)
  );

  always #5 clk = ~clk;

`ifdef AD_PAD_EN
  localparam logic [7:0] PadB = 8'h80;
`else
  localparam logic [7:0] PadB = 8'h00;
`endif

  typedef struct {
    logic [63:0] d;
    logic [3:0]  len;
    logic        last;
  } blk_t;

  typedef struct {
    int         n;
    logic [7:0] base;
    int         dly;
    int         exp_total;
    bit         exp_err;
  } vec_t;

  blk_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Expected blocks from a plain description of the framing: 8-byte chunks, then a padded tail.
  task automatic build_expect(input int n, input logic [7:0] base);
    int k, rem, nfull;
    bit err;
    blk_t b;
    k = (n > MaxAd) ? MaxAd : n;
    err = (n > MaxAd);
    nfull = k / 8;
    rem = k % 8;
    for (int c = 0; c < nfull; c++) begin
      b.d = '0;
      for (int l = 0; l < 8; l++) b.d[63-8*l -: 8] = 8'(base + 8'(8*c + l));
      b.len = 4'd8;
      b.last = 1'b0;
      exp_q.push_back(b);
    end
    if (rem > 0) begin
      b.d = '0;
      for (int l = 0; l < rem; l++) b.d[63-8*l -: 8] = 8'(base + 8'(8*nfull + l));
      b.d[63-8*rem -: 8] = PadB;
      b.len = 4'(rem);
      b.last = 1'b1;
      exp_q.push_back(b);
    end else if (!err && k > 0) begin
      b.d = {PadB, 56'h0};
      b.len = 4'd0;
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic run_msg(input int n, input logic [7:0] base, input int dly,
                         input int exp_total, input bit exp_err);
    int   sent, cyc, hold;
    blk_t b;
    exp_q.delete();
    build_expect(n, base);
    @(negedge clk);
    start = 1'b1;
    ad_empty = 1'b0;
    @(negedge clk);
    start = 1'b0;
    sent = 0;
    cyc = 0;
    hold = 0;
    while (done !== 1'b1 && cyc < 400) begin
      AD_read = 1'b0;
      ad_valid = 1'b0;
      ad_last = 1'b0;
      if (block_valid === 1'b1) begin
        if (hold < dly) begin
          chk("ready_low_in_hold", 64'(ad_ready), 64'd0);
          if (exp_q.size() > 0) chk("data_stable", block_data, exp_q[0].d);
          hold++;
        end else begin
          if (exp_q.size() == 0) begin
            chk("unexpected_block", 64'(block_valid), 64'd0);
          end else begin
            b = exp_q.pop_front();
            chk("block_data", block_data, b.d);
            chk("block_len", 64'(block_len), 64'(b.len));
            chk("block_last", 64'(block_last), 64'(b.last));
          end
          AD_read = 1'b1;
          hold = 0;
        end
      end else if (ad_ready === 1'b1 && sent < n) begin
        ad_valid = 1'b1;
        ad_byte = 8'(base + 8'(sent));
        ad_last = (sent == n - 1);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    AD_read = 1'b0;
    ad_valid = 1'b0;
    ad_last = 1'b0;
    chk("done_reached", 64'(done), 64'd1);
    chk("all_blocks_seen", 64'(exp_q.size()), 64'd0);
    chk("ad_total", 64'(ad_total), 64'(exp_total));
    chk("ad_err", 64'(ad_err), 64'(exp_err));
    chk("no_valid_in_done", 64'(block_valid), 64'd0);
    @(negedge clk);
    chk("done_held", 64'(done), 64'd1);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{n: 5,  base: 8'h01, dly: 0, exp_total: 5,  exp_err: 1'b0};
    vecs[1] = '{n: 8,  base: 8'h11, dly: 0, exp_total: 8,  exp_err: 1'b0};
    vecs[2] = '{n: 12, base: 8'h21, dly: 5, exp_total: 12, exp_err: 1'b0};
    vecs[3] = '{n: 17, base: 8'h31, dly: 1, exp_total: 15, exp_err: 1'b1};
    vecs[4] = '{n: 1,  base: 8'h41, dly: 2, exp_total: 1,  exp_err: 1'b0};
    vecs[5] = '{n: 15, base: 8'h51, dly: 0, exp_total: 15, exp_err: 1'b0};
    vecs[6] = '{n: 16, base: 8'h61, dly: 0, exp_total: 15, exp_err: 1'b1};
    vecs[7] = '{n: 9,  base: 8'h71, dly: 3, exp_total: 9,  exp_err: 1'b0};

    // Reset state.
    #1;
    chk("rst_ready", 64'(ad_ready), 64'd0);
    chk("rst_valid", 64'(block_valid), 64'd0);
    chk("rst_data", block_data, 64'd0);
    chk("rst_total", 64'(ad_total), 64'd0);
    chk("rst_done_err", 64'({done, ad_err, block_last}), 64'd0);
    #20;
    @(negedge clk);
    nRST = 1'b1;

    // Reset mid-FILL after 3 bytes.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("fill_ready", 64'(ad_ready), 64'd1);
      ad_valid = 1'b1;
      ad_byte = 8'(8'hA0 + 8'(i));
      @(negedge clk);
    end
    ad_valid = 1'b0;
    chk("partial_total", 64'(ad_total), 64'd3);
    nRST = 1'b0;
    #1;
    chk("midrst_ready", 64'(ad_ready), 64'd0);
    chk("midrst_total", 64'(ad_total), 64'd0);
    chk("midrst_outs", 64'({block_valid, done, ad_err, block_len}), 64'd0);
    @(negedge clk);
    nRST = 1'b1;

    // Table-driven messages; the first also shows a fresh start packs from lane 0.
    for (int v = 0; v < 8; v++) begin
      run_msg(vecs[v].n, vecs[v].base, vecs[v].dly, vecs[v].exp_total, vecs[v].exp_err);
    end

    // Empty AD: straight to DONE, no blocks.
    @(negedge clk);
    start = 1'b1;
    ad_empty = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ad_empty = 1'b0;
    chk("empty_done", 64'(done), 64'd1);
    chk("empty_total", 64'(ad_total), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("empty_no_valid", 64'(block_valid), 64'd0);
      @(negedge clk);
    end

    // A byte offered in the start cycle is not accepted; AD_read without a block is ignored.
    start = 1'b1;
    ad_valid = 1'b1;
    ad_byte = 8'hEE;
    @(negedge clk);
    start = 1'b0;
    ad_valid = 1'b0;
    chk("start_prio_total", 64'(ad_total), 64'd0);
    chk("start_prio_ready", 64'(ad_ready), 64'd1);
    AD_read = 1'b1;
    @(negedge clk);
    AD_read = 1'b0;
    chk("stray_read_ready", 64'(ad_ready), 64'd1);
    chk("stray_read_valid", 64'(block_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
